// File: rtl/mcp3202_chan_sched.sv
// MCP3202 conversion scheduler: frame timebase, per-channel start/collect FSM, AXI-Stream result port.
// Define MCP3202_SCHED_OVR_CNT_EN to add the saturating skipped-frame counter output ovr_cnt.
module mcp3202_chan_sched #(
    parameter int         FCLK        = 100_000_000,
    parameter int         FSMPL       = 500,
    parameter logic [1:0] CH_EN       = 2'b11,
    parameter bit         SGL         = 1'b1,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        cnv_start,
    output logic        cnv_sgl,
    output logic        cnv_odd,
    input  logic        cnv_done,
    input  logic [11:0] cnv_data,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic        ovr,
    output logic        tmo
`ifdef MCP3202_SCHED_OVR_CNT_EN
    ,
    output logic [7:0]  ovr_cnt
`endif
);

    localparam int   PERIOD = FCLK / FSMPL;
    localparam int   TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int   OW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic LO_CH  = ~CH_EN[0];

    if (CH_EN == 2'b00) begin : g_ch_en_illegal
        $error("mcp3202_chan_sched: CH_EN must enable at least one channel");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUSH} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q;
    logic            ch_q, ch_d;
    logic            sgl_q, sgl_d;
    logic [OW-1:0]   tocnt_q, tocnt_d;
    logic [15:0]     tdata_q, tdata_d;
    logic            tuser_q, tuser_d;
    logic            tlast_q, tlast_d;
    logic            tvalid_q, tvalid_d;
    logic            ovr_q, ovr_d;
    logic            tmo_q, tmo_d;
`ifdef MCP3202_SCHED_OVR_CNT_EN
    logic [7:0]      ovr_cnt_q, ovr_cnt_d;
`endif
    logic            frame_tick;
    logic            handshake;
    logic            timeout;
    logic            last_ch;

    assign frame_tick = (tick_q == TW'(PERIOD - 1));
    assign handshake  = tvalid_q & m_axis_tready;
    assign timeout    = (tocnt_q == OW'(TIMEOUT_CYC - 1));
    assign last_ch    = ch_q | ~CH_EN[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          tick_q <= '0;
        else if (frame_tick) tick_q <= '0;
        else                 tick_q <= tick_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= 1'b0;
            sgl_q     <= 1'b0;
            tocnt_q   <= '0;
            tdata_q   <= '0;
            tuser_q   <= 1'b0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
`ifdef MCP3202_SCHED_OVR_CNT_EN
            ovr_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            sgl_q     <= sgl_d;
            tocnt_q   <= tocnt_d;
            tdata_q   <= tdata_d;
            tuser_q   <= tuser_d;
            tlast_q   <= tlast_d;
            tvalid_q  <= tvalid_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
`ifdef MCP3202_SCHED_OVR_CNT_EN
            ovr_cnt_q <= ovr_cnt_d;
`endif
        end
    end

    // The last beat of a frame is left in the output register while the FSM returns
    // to IDLE, so a stalled sink shows up as a pending tvalid at the next frame tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_tick && !tvalid_q) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnv_done)                state_d = PUSH;
                     else if (timeout)            state_d = IDLE;
            PUSH:    if (tlast_q)                 state_d = IDLE;
                     else if (handshake)          state_d = ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_d      = ch_q;
        sgl_d     = sgl_q;
        tocnt_d   = tocnt_q;
        tdata_d   = tdata_q;
        tuser_d   = tuser_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q;
        ovr_d     = ovr_q;
        tmo_d     = tmo_q;
`ifdef MCP3202_SCHED_OVR_CNT_EN
        ovr_cnt_d = ovr_cnt_q;
`endif
        if (handshake) tvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    if (tvalid_q) begin
                        ovr_d = 1'b1;
`ifdef MCP3202_SCHED_OVR_CNT_EN
                        if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
`endif
                    end else begin
                        ch_d  = LO_CH;
                        sgl_d = SGL;
                    end
                end
            end
            // tocnt holds the number of cycles elapsed since cnv_start
            ISSUE: tocnt_d = OW'(1);
            WAIT: begin
                tocnt_d = tocnt_q + OW'(1);
                if (cnv_done) begin
                    tdata_d  = {4'h0, cnv_data};
                    tuser_d  = ch_q;
                    tlast_d  = last_ch;
                    tvalid_d = 1'b1;
                end else if (timeout) begin
                    tmo_d = 1'b1;
                end
            end
            PUSH: begin
                if (!tlast_q && handshake) begin
                    ch_d  = 1'b1;
                    sgl_d = SGL;
                end
            end
            default: ;
        endcase

        cnv_start     = (state_q == ISSUE);
        cnv_sgl       = sgl_q;
        cnv_odd       = ch_q;
        busy          = (state_q != IDLE);
        m_axis_tdata  = tdata_q;
        m_axis_tuser  = tuser_q;
        m_axis_tlast  = tlast_q;
        m_axis_tvalid = tvalid_q;
        ovr           = ovr_q;
        tmo           = tmo_q;
`ifdef MCP3202_SCHED_OVR_CNT_EN
        ovr_cnt       = ovr_cnt_q;
`endif
    end

endmodule

// File: tb/tb_mcp3202_chan_sched.sv
// Directed self-checking bench for mcp3202_chan_sched: dutA (both channels, short timeout)
// and dutB (CH0 only) with a 100-cycle frame period; inputs driven and outputs sampled on negedge.
module tb_mcp3202_chan_sched;

    localparam int PERIOD = 100;

    logic        clk;
    logic        rstNA, rstNB;

    logic        startA, sglA, oddA, doneA, tuserA, tlastA, tvalidA, treadyA, busyA, ovrA, tmoA;
    logic [11:0] dataA;
    logic [15:0] tdataA;
    logic        startB, sglB, oddB, doneB, tuserB, tlastB, tvalidB, treadyB, busyB, ovrB, tmoB;
    logic [11:0] dataB;
    logic [15:0] tdataB;
`ifdef MCP3202_SCHED_OVR_CNT_EN
    logic [7:0]  ovrCntA, ovrCntB;
`endif

    int cyc       = 0;
    int nCompared = 0;
    int nMismatch = 0;

    mcp3202_chan_sched #(
        .FCLK(1000), .FSMPL(10), .CH_EN(2'b11), .SGL(1'b1), .TIMEOUT_CYC(64)
    ) dutA (
        .clk(clk), .rst_n(rstNA),
        .cnv_start(startA), .cnv_sgl(sglA), .cnv_odd(oddA),
        .cnv_done(doneA), .cnv_data(dataA),
        .m_axis_tdata(tdataA), .m_axis_tuser(tuserA), .m_axis_tlast(tlastA),
        .m_axis_tvalid(tvalidA), .m_axis_tready(treadyA),
        .busy(busyA), .ovr(ovrA), .tmo(tmoA)
`ifdef MCP3202_SCHED_OVR_CNT_EN
        , .ovr_cnt(ovrCntA)
`endif
    );

    mcp3202_chan_sched #(
        .FCLK(1000), .FSMPL(10), .CH_EN(2'b01), .SGL(1'b1), .TIMEOUT_CYC(64)
    ) dutB (
        .clk(clk), .rst_n(rstNB),
        .cnv_start(startB), .cnv_sgl(sglB), .cnv_odd(oddB),
        .cnv_done(doneB), .cnv_data(dataB),
        .m_axis_tdata(tdataB), .m_axis_tuser(tuserB), .m_axis_tlast(tlastB),
        .m_axis_tvalid(tvalidB), .m_axis_tready(treadyB),
        .busy(busyB), .ovr(ovrB), .tmo(tmoB)
`ifdef MCP3202_SCHED_OVR_CNT_EN
        , .ovr_cnt(ovrCntB)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitStartA(input int bound, output int at);
        int n = 0;
        while (!startA && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("startA_seen", 32'(startA), 32'd1);
        at = cyc;
    endtask

    task automatic waitStartB(input int bound, output int at);
        int n = 0;
        while (!startB && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("startB_seen", 32'(startB), 32'd1);
        at = cyc;
    endtask

    // Called at the negedge where cnv_start is visible; returns at the negedge where the beat is visible.
    task automatic applyStimulusA(input logic [11:0] d);
        repeat (3) @(negedge clk);
        doneA = 1'b1;
        dataA = d;
        @(negedge clk);
        doneA = 1'b0;
    endtask

    task automatic applyStimulusB(input logic [11:0] d);
        repeat (3) @(negedge clk);
        doneB = 1'b1;
        dataB = d;
        @(negedge clk);
        doneB = 1'b0;
    endtask

    initial begin
        int          rel, t, s, k, beat0At, beat1At, nStart;
        logic        sawValid, hs, expCh;
        logic [11:0] d;

        rstNA = 1'b0; rstNB = 1'b0;
        doneA = 1'b0; dataA = '0; treadyA = 1'b1;
        doneB = 1'b0; dataB = '0; treadyB = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rstA_ctrl", 32'({startA, sglA, oddA, tvalidA, tuserA, tlastA, busyA, ovrA, tmoA}), 32'd0);
        checkOutput("rstA_tdata", 32'(tdataA), 32'd0);
`ifdef MCP3202_SCHED_OVR_CNT_EN
        checkOutput("rstA_ovr_cnt", 32'(ovrCntA), 32'd0);
`endif

        // Two-channel frames with an always-ready sink
        @(negedge clk);
        rstNA = 1'b1;
        rel = cyc;
        waitStartA(250, t);
        checkOutput("t1_first_start_lat", 32'(t - rel), 32'd100);
        checkOutput("t1_cfg_ch0", 32'({sglA, oddA}), 32'b10);
        applyStimulusA(12'h75F);
        checkOutput("t1_beat0", 32'({tvalidA, tuserA, tlastA, tdataA}), 32'({3'b100, 16'h075F}));
        beat0At = cyc;
        @(negedge clk);
        checkOutput("t1_issue_after_hs", 32'({tvalidA, startA, sglA, oddA}), 32'b0111);
        applyStimulusA(12'h4E8);
        checkOutput("t1_beat1", 32'({tvalidA, tuserA, tlastA, tdataA}), 32'({3'b111, 16'h04E8}));
        beat1At = cyc;
        @(negedge clk);
        checkOutput("t1_idle_after_last", 32'({tvalidA, busyA}), 32'd0);

        waitStartA(250, t);
        checkOutput("t1_frame2_start", 32'(t - rel), 32'(2 * PERIOD));
        checkOutput("t1_frame2_odd", 32'(oddA), 32'd0);
        applyStimulusA(12'h75F);
        checkOutput("t1_f2_beat0", 32'({tvalidA, tuserA, tlastA, tdataA}), 32'({3'b100, 16'h075F}));
        checkOutput("t1_beat0_spacing", 32'(cyc - beat0At), 32'(PERIOD));
        @(negedge clk);
        waitStartA(5, t);
        applyStimulusA(12'h4E8);
        checkOutput("t1_f2_beat1", 32'({tvalidA, tuserA, tlastA, tdataA}), 32'({3'b111, 16'h04E8}));
        checkOutput("t1_beat1_spacing", 32'(cyc - beat1At), 32'(PERIOD));
        @(negedge clk);

        // Spurious cnv_done while idle must be ignored
        doneA = 1'b1;
        dataA = 12'hFFF;
        @(negedge clk);
        doneA = 1'b0;
        @(negedge clk);
        checkOutput("t5_spurious_idle", 32'({tvalidA, busyA, tdataA}), 32'({2'b00, 16'h04E8}));

        // cnv_done in the last timeout cycle wins over the timeout
        waitStartA(250, t);
        s = t;
        checkOutput("t5_frame3_start", 32'(t - rel), 32'(3 * PERIOD));
        repeat (63) @(negedge clk);
        doneA = 1'b1;
        dataA = 12'hABC;
        @(negedge clk);
        doneA = 1'b0;
        checkOutput("t5_coincident_beat", 32'({tvalidA, tuserA, tlastA, tdataA}), 32'({3'b100, 16'h0ABC}));
        checkOutput("t5_coincident_tmo", 32'(tmoA), 32'd0);
        checkOutput("t5_coincident_lat", 32'(cyc - s), 32'd64);

        // CH1 conversion never completes
        @(negedge clk);
        waitStartA(5, t);
        checkOutput("t3_cfg_ch1", 32'({sglA, oddA}), 32'b11);
        sawValid = 1'b0;
        k = 0;
        while (!tmoA && k < 100) begin
            @(negedge clk);
            k++;
            if (tvalidA) sawValid = 1'b1;
        end
        checkOutput("t3_tmo_latency", 32'(k), 32'd64);
        checkOutput("t3_no_tvalid", 32'(sawValid), 32'd0);
        checkOutput("t3_idle_after_tmo", 32'({busyA, tmoA}), 32'b01);
        checkOutput("t3_no_ovr_busy_tick", 32'(ovrA), 32'd0);
        waitStartA(250, t);
        checkOutput("t3_next_frame_start", 32'(t - rel), 32'(5 * PERIOD));
        checkOutput("t3_next_frame_odd", 32'(oddA), 32'd0);

        // Asynchronous reset while waiting on CH1
        applyStimulusA(12'h123);
        checkOutput("t4_beat0", 32'({tvalidA, tuserA, tlastA, tdataA}), 32'({3'b100, 16'h0123}));
        @(negedge clk);
        waitStartA(5, t);
        repeat (2) @(negedge clk);
        checkOutput("t4_in_wait_ch1", 32'({busyA, oddA, tmoA}), 32'b111);
        rstNA = 1'b0;
        #1;
        checkOutput("t4_async_ctrl", 32'({startA, sglA, oddA, tvalidA, tuserA, tlastA, busyA, ovrA, tmoA}), 32'd0);
        checkOutput("t4_async_tdata", 32'(tdataA), 32'd0);
        @(negedge clk);
        rstNA = 1'b1;
        rel = cyc;
        waitStartA(250, t);
        checkOutput("t4_restart_lat", 32'(t - rel), 32'(PERIOD));
        checkOutput("t4_restart_odd", 32'(oddA), 32'd0);

        // Random backpressure over 200 frames
        expCh = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i > 0) waitStartA(250, t);
            checkOutput("t6_odd", 32'(oddA), 32'(expCh));
            d = 12'($urandom);
            applyStimulusA(d);
            checkOutput("t6_beat", 32'({tvalidA, tuserA, tlastA, tdataA}), 32'({1'b1, expCh, expCh, 4'h0, d}));
            hs = 1'b0;
            k = 0;
            while (!hs && k < 90) begin
                treadyA = 1'($urandom_range(0, 1));
                @(negedge clk);
                k++;
                if (treadyA) hs = 1'b1;
                else checkOutput("t6_stable", 32'({tvalidA, tuserA, tlastA, tdataA}),
                                 32'({1'b1, expCh, expCh, 4'h0, d}));
            end
            checkOutput("t6_handshake", 32'(hs), 32'd1);
            checkOutput("t6_valid_drop", 32'(tvalidA), 32'd0);
            expCh = ~expCh;
        end
        checkOutput("t6_flags", 32'({ovrA, tmoA}), 32'd0);
        rstNA = 1'b0;

        // CH0-only build with a stalled sink: frames are skipped, beat held
        @(negedge clk);
        rstNB = 1'b1;
        rel = cyc;
        treadyB = 1'b0;
        waitStartB(250, t);
        checkOutput("t2_first_start", 32'(t - rel), 32'(PERIOD));
        checkOutput("t2_cfg", 32'({sglB, oddB}), 32'b10);
        applyStimulusB(12'h7FF);
        checkOutput("t2_beat", 32'({tvalidB, tuserB, tlastB, tdataB}), 32'({3'b101, 16'h07FF}));
        nStart = 0;
        while (cyc - rel < 450) begin
            @(negedge clk);
            if (startB) nStart++;
            if (!tvalidB || tdataB !== 16'h07FF) sawValid = 1'b0;
        end
        checkOutput("t2_no_start", 32'(nStart), 32'd0);
        checkOutput("t2_held_beat", 32'({tvalidB, tuserB, tlastB, tdataB}), 32'({3'b101, 16'h07FF}));
        checkOutput("t2_flags", 32'({busyB, ovrB, tmoB}), 32'b010);
`ifdef MCP3202_SCHED_OVR_CNT_EN
        checkOutput("t2_ovr_cnt", 32'(ovrCntB), 32'd3);
`endif
        treadyB = 1'b1;
        @(negedge clk);
        checkOutput("t2_drained", 32'(tvalidB), 32'd0);
        waitStartB(100, t);
        checkOutput("t2_resume_start", 32'(t - rel), 32'(5 * PERIOD));
        applyStimulusB(12'h001);
        checkOutput("t2_resume_beat", 32'({tvalidB, tuserB, tlastB, tdataB}), 32'({3'b101, 16'h0001}));
        checkOutput("t2_ovr_sticky", 32'(ovrB), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
